// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor: PC_SEL encodings,
// branch opcode, counter states and the table entry layout.
package branch_predictor_pkg;

    // Resolved next-PC selection coming back from EX
    localparam logic [2:0] PCSEL_SEQ  = 3'b000;
    localparam logic [2:0] PCSEL_JALR = 3'b001;
    localparam logic [2:0] PCSEL_BR   = 3'b010;
    localparam logic [2:0] PCSEL_JAL  = 3'b011;

    // Conditional branch major opcode
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // 2-bit saturating counter states; MSB is the taken prediction
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // One table entry; tag is held zero-extended so the layout is width-independent
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        logic [1:0]  ctr;
    } bp_entry_t;

    // Any non-sequential PC_SEL means control left the fall-through path
    function automatic logic pc_sel_taken(input logic [2:0] sel);
        return sel != PCSEL_SEQ;
    endfunction

    function automatic logic is_branch_op(input logic [6:0] opcode);
        return opcode == OP_BRANCH;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and EX resolution signals between the pipeline (master)
// and the branch predictor (slave).
interface branch_predictor_if;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic [2:0]  ex_pc_sel;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_is_branch, ex_pc_sel, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_is_branch, ex_pc_sel, ex_target,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc
    );
endinterface

// File: rtl/branch_predictor_sat_ctr.sv
// 2-bit saturating counter next-state function: inc/dec move one step,
// the end states 00 and 11 hold.
module branch_predictor_sat_ctr
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] ctr_next
);

    // Step the counter, clamping at both ends
    always_comb begin
        ctr_next = ctr;
        if (inc && !dec && ctr != CTR_ST) begin
            ctr_next = ctr + 2'd1;
        end else if (dec && !inc && ctr != CTR_SNT) begin
            ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters. Lookup with the IF PC is purely
// combinational from the current table; the EX outcome trains the table on
// the rising edge and is compared with the prediction carried down the pipe.
// Optional macro BP_STATS_EN adds saturating branch/mispredict counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    branch_predictor_if.slave bp
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;

    // Table: only valid bits are reset, payload arrays are written before use
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    bp_entry_t        if_ent;
    logic             if_hit, ex_hit, actual_taken;
    logic [1:0]       ex_ctr_next;
    logic             unused_pc;

    assign if_idx = bp.if_pc[IDX_W+1:2];
    assign ex_idx = bp.ex_pc[IDX_W+1:2];
    assign if_tag = bp.if_pc[TAG_LO+TAG_W-1:TAG_LO];
    assign ex_tag = bp.ex_pc[TAG_LO+TAG_W-1:TAG_LO];
    assign unused_pc = ^{bp.if_pc, bp.ex_pc};

    // Fetch-side read of the indexed entry (pre-update state, no bypass)
    always_comb begin
        if_ent.valid  = valid_q[if_idx];
        if_ent.tag    = {{(32-TAG_W){1'b0}}, tag_q[if_idx]};
        if_ent.target = target_q[if_idx];
        if_ent.ctr    = ctr_q[if_idx];
    end

    assign if_hit         = if_ent.valid && (if_ent.tag == {{(32-TAG_W){1'b0}}, if_tag});
    assign bp.pred_taken  = if_hit && if_ent.ctr[1];
    assign bp.pred_target = bp.pred_taken ? if_ent.target : bp.if_pc + 32'd4;

    // EX-side resolution and compare against the piped prediction
    assign ex_hit         = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign actual_taken   = pc_sel_taken(bp.ex_pc_sel);
    assign bp.mispredict  = bp.ex_valid &&
                            ((actual_taken != bp.ex_pred_taken) ||
                             (actual_taken && (bp.ex_target != bp.ex_pred_target)));
    assign bp.redirect_pc = actual_taken ? bp.ex_target : bp.ex_pc + 32'd4;

    branch_predictor_sat_ctr u_sat_ctr (
        .ctr      (ctr_q[ex_idx]),
        .inc      (actual_taken),
        .dec      (!actual_taken),
        .ctr_next (ex_ctr_next)
    );

    logic       set_valid, clr_valid, wr_tag, wr_target, wr_ctr;
    logic [1:0] ctr_wdata;

    // Decide which fields of the EX entry get written this cycle
    always_comb begin
        set_valid = 1'b0;
        clr_valid = 1'b0;
        wr_tag    = 1'b0;
        wr_target = 1'b0;
        wr_ctr    = 1'b0;
        ctr_wdata = ex_ctr_next;
        if (bp.ex_valid) begin
            if (bp.ex_is_branch) begin
                if (ex_hit) begin
                    wr_ctr    = 1'b1;
                    wr_target = actual_taken;
                end else if (actual_taken) begin
                    set_valid = 1'b1;
                    wr_tag    = 1'b1;
                    wr_target = 1'b1;
                    wr_ctr    = 1'b1;
                    ctr_wdata = CTR_WT;
                end
            end else if (bp.ex_pc_sel == PCSEL_JAL) begin
                set_valid = 1'b1;
                wr_tag    = 1'b1;
                wr_target = 1'b1;
                wr_ctr    = 1'b1;
                ctr_wdata = CTR_ST;
            end else if (bp.ex_pc_sel == PCSEL_JALR && ex_hit) begin
                clr_valid = 1'b1;
            end
        end
    end

    // Valid bits: cleared by reset, set on allocation, cleared by JALR hits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[ex_idx] <= 1'b1;
        end else if (clr_valid) begin
            valid_q[ex_idx] <= 1'b0;
        end
    end

    // Entry payload, unreset
    always_ff @(posedge clk) begin
        if (wr_tag)    tag_q[ex_idx]    <= ex_tag;
        if (wr_target) target_q[ex_idx] <= bp.ex_target;
        if (wr_ctr)    ctr_q[ex_idx]    <= ctr_wdata;
    end

`ifdef BP_STATS_EN
    logic counted;
    assign counted = bp.ex_valid &&
                     (bp.ex_is_branch || bp.ex_pc_sel == PCSEL_JALR || bp.ex_pc_sel == PCSEL_JAL);

    // Saturating statistics counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (counted && stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
            if (bp.mispredict && stat_mispred != 32'hFFFF_FFFF) stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=64, TAG_W=8).
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    branch_predictor_if bp();

`ifdef BP_STATS_EN
    logic [31:0] stat_branches, stat_mispred;
`endif

    branch_predictor #(.ENTRIES(64), .TAG_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp)
`ifdef BP_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
`endif
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ex_drive(input logic br, input logic [2:0] sel, input logic [31:0] pc,
                            input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        bp.ex_valid       = 1'b1;
        bp.ex_is_branch   = br;
        bp.ex_pc_sel      = sel;
        bp.ex_pc          = pc;
        bp.ex_target      = tgt;
        bp.ex_pred_taken  = pt;
        bp.ex_pred_target = ptgt;
    endtask

    task automatic ex_idle();
        bp.ex_valid       = 1'b0;
        bp.ex_is_branch   = 1'b0;
        bp.ex_pc_sel      = 3'b000;
        bp.ex_pc          = 32'h0;
        bp.ex_target      = 32'h0;
        bp.ex_pred_taken  = 1'b0;
        bp.ex_pred_target = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic taken,
                        input logic [31:0] tgt);
        bp.if_pc = pc;
        #1;
        check({tag, "_taken"}, {31'd0, bp.pred_taken}, {31'd0, taken});
        check({tag, "_target"}, bp.pred_target, tgt);
    endtask

    task automatic resolve(input string tag, input logic mp, input logic [31:0] redir);
        #1;
        check({tag, "_mp"}, {31'd0, bp.mispredict}, {31'd0, mp});
        if (mp) check({tag, "_redir"}, bp.redirect_pc, redir);
    endtask

    initial begin
        rst_n    = 1'b0;
        bp.if_pc = 32'h100;
        ex_idle();
        #12;
        // Reset state
        look("rst", 32'h100, 1'b0, 32'h104);
        check("rst_mp", {31'd0, bp.mispredict}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Taken branch at 0x100 allocates; same-cycle lookup still sees old state
        ex_drive(1'b1, 3'b010, 32'h100, 32'h80, 1'b0, 32'h104);
        resolve("alloc", 1'b1, 32'h80);
        look("same_cyc", 32'h100, 1'b0, 32'h104);
        tick();
        ex_idle();
        look("after_alloc", 32'h100, 1'b1, 32'h80);
        look("alias", 32'h200, 1'b0, 32'h204);

        // EX_VALID low: no mispredict, no training
        ex_drive(1'b1, 3'b000, 32'h100, 32'h104, 1'b1, 32'h80);
        bp.ex_valid = 1'b0;
        resolve("ex_inval", 1'b0, 32'h0);
        tick();
        ex_idle();
        look("no_train", 32'h100, 1'b1, 32'h80);

        // Not-taken training 10 -> 01 -> 00 -> 00, then taken 00 -> 01
        ex_drive(1'b1, 3'b000, 32'h100, 32'h104, 1'b1, 32'h80);
        resolve("nt1", 1'b1, 32'h104);
        tick();
        ex_idle();
        look("ctr01", 32'h100, 1'b0, 32'h104);
        ex_drive(1'b1, 3'b000, 32'h100, 32'h104, 1'b0, 32'h104);
        resolve("nt2", 1'b0, 32'h0);
        tick();
        ex_idle();
        look("ctr00", 32'h100, 1'b0, 32'h104);
        ex_drive(1'b1, 3'b000, 32'h100, 32'h104, 1'b0, 32'h104);
        tick();
        ex_drive(1'b1, 3'b010, 32'h100, 32'h80, 1'b0, 32'h104);
        resolve("t_after_sat", 1'b1, 32'h80);
        tick();
        ex_idle();
        look("hold00", 32'h100, 1'b0, 32'h104);

        // Plain sequential instruction: never a mispredict
        ex_drive(1'b0, 3'b000, 32'h104, 32'h108, 1'b0, 32'h108);
        resolve("seq", 1'b0, 32'h0);
        tick();
        ex_idle();

        // Predicted taken to 0x80 but resolved taken to 0x90
        ex_drive(1'b1, 3'b010, 32'h140, 32'h80, 1'b0, 32'h144);
        resolve("t6_alloc", 1'b1, 32'h80);
        tick();
        ex_idle();
        look("t6_pred", 32'h140, 1'b1, 32'h80);
        ex_drive(1'b1, 3'b010, 32'h140, 32'h90, 1'b1, 32'h80);
        resolve("t6_tgt", 1'b1, 32'h90);
        tick();
        ex_idle();
        look("t6_new", 32'h140, 1'b1, 32'h90);

        // JAL allocates strong-taken, replacing the index-0 entry
        ex_drive(1'b0, 3'b011, 32'h200, 32'h400, 1'b0, 32'h204);
        resolve("jal", 1'b1, 32'h400);
        tick();
        ex_idle();
        look("jal_pred", 32'h200, 1'b1, 32'h400);
        look("jal_evict", 32'h100, 1'b0, 32'h104);

        // JALR: never allocates; a tag miss leaves the entry, a hit invalidates it
        ex_drive(1'b0, 3'b001, 32'h300, 32'h500, 1'b0, 32'h304);
        resolve("jalr_miss", 1'b1, 32'h500);
        tick();
        ex_idle();
        look("jalr_none", 32'h300, 1'b0, 32'h304);
        look("jalr_keep", 32'h200, 1'b1, 32'h400);
        ex_drive(1'b0, 3'b001, 32'h200, 32'h400, 1'b1, 32'h400);
        resolve("jalr_hit", 1'b0, 32'h0);
        tick();
        ex_idle();
        look("jalr_inv", 32'h200, 1'b0, 32'h204);

`ifdef BP_STATS_EN
        check("stat_br", stat_branches, 32'd10);
        check("stat_mp", stat_mispred, 32'd7);
`endif

        // Asynchronous reset between clock edges
        bp.if_pc = 32'h140;
        #2;
        rst_n = 1'b0;
        look("arst", 32'h140, 1'b0, 32'h144);
`ifdef BP_STATS_EN
        check("arst_stat_br", stat_branches, 32'd0);
        check("arst_stat_mp", stat_mispred, 32'd0);
`endif
        #3;
        rst_n = 1'b1;
        tick();
        look("post_rst", 32'h140, 1'b0, 32'h144);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
